// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming_pkg
// Description : Shared types and helpers for the sequential Hamming
//               weight / distance unit.
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    // Controller states of the multi-cycle counter
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold a ones count of a w-bit vector (0..w inclusive)
    function automatic int popcount_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : hamming_pkg
`default_nettype wire

// File: rtl/chunk_popcount.sv
`default_nettype none
// ============================================================================
// Module      : chunk_popcount
// Description : Combinational ones counter for one CHUNK-bit slice.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_popcount
    import hamming_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0]                  i_bits,
    output logic [popcount_width(CHUNK)-1:0]  o_ones
);

    localparam int PW = popcount_width(CHUNK);

    // Sum the individual bits of the slice
    always_comb begin
        o_ones = '0;
        for (int i = 0; i < CHUNK; i++) begin
            o_ones = o_ones + PW'(i_bits[i]);
        end
    end

endmodule : chunk_popcount
`default_nettype wire

// File: rtl/hamming_seq.sv
`default_nettype none
// ============================================================================
// Module      : hamming_seq
// Description : Multi-cycle Hamming weight (mode=0) / Hamming distance
//               (mode=1) unit. Counts CHUNK bits per cycle with a
//               start / busy / done handshake; latency is WIDTH/CHUNK + 1.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_seq
    import hamming_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mode,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int N  = WIDTH / CHUNK;
    localparam int PW = popcount_width(CHUNK);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] c_IDLE = IDLE;
    localparam logic [1:0] c_RUN  = RUN;
    localparam logic [1:0] c_DONE = DONE;

    // Reject illegal configurations while elaborating
    generate
        if (WIDTH < 1) begin : g_bad_width
            $fatal(1, "hamming_seq: WIDTH (%0d) must be >= 1", WIDTH);
        end
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
            $fatal(1, "hamming_seq: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
        end
    endgenerate

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_acc;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_count;

    logic [PW-1:0]    w_ones;
    logic [CW-1:0]    w_sum;
    logic             w_last;
    logic [WIDTH-1:0] w_operand;

    chunk_popcount #(
        .CHUNK (CHUNK)
    ) u_chunk_popcount (
        .i_bits (r_sr[CHUNK-1:0]),
        .o_ones (w_ones)
    );

    // Running sum including the slice being counted this cycle
    assign w_sum     = r_acc + CW'(w_ones);
    assign w_last    = (r_idx == IW'(N - 1));
    assign w_operand = mode ? (a ^ b) : a;

    // FSM, shift register, accumulator and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_sr    <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_sr    <= w_operand;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_acc <= w_sum;
                    r_sr  <= r_sr >> CHUNK;
                    r_idx <= r_idx + IW'(1);
                    if (w_last) begin
                        r_count <= w_sum;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    // A start here chains the next request with no idle gap
                    if (start) begin
                        r_sr    <= w_operand;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= c_RUN;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Status outputs decode straight from the state register
    assign busy  = (r_state == c_RUN);
    assign done  = (r_state == c_DONE);
    assign count = r_count;

endmodule : hamming_seq
`default_nettype wire

// File: doc/hamming_seq.md
# hamming_seq

Multi-cycle, parametrised Hamming weight / Hamming distance unit. It is the sequential successor to the 16-bit combinational popcount: it supports any WIDTH, processes CHUNK bits per cycle, and has a start/busy/done handshake. A mode input selects between the weight of one operand and the distance between two. It sits beside the datapath as a shared counting resource, driven by a controller that issues one request at a time.

## Interface
- WIDTH, 16, operand width in bits; must be ≥ 1.
- CHUNK, 4, bits counted per cycle; WIDTH % CHUNK must be 0, otherwise `$fatal` at elaboration.
- CW (localparam), `$clog2(WIDTH+1)`, count width; 5 for WIDTH=16.
- N (localparam), WIDTH/CHUNK, number of RUN cycles.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- mode  in  1  0 = weight of a; 1 = distance, i.e. weight of a ^ b.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start, ignored when mode=0.
- busy  out  1  high in every RUN cycle.
- done  out  1  one-cycle pulse; count is valid in that cycle.
- count  out  CW  result; holds the last result until the next done.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **IDLE.** busy=0, done=0. If start=1, at the edge:
  - shift register sr ← (mode ? a^b : a);
  - acc ← 0; idx ← 0; next state RUN.
- **RUN.** busy=1. Each edge: acc ← acc + popcount(sr[CHUNK-1:0]); sr ← sr >> CHUNK; idx ← idx+1.
  - The RUN cycle with idx = N-1 also writes count ← final acc sum and moves to DONE.
- **DONE.** done=1, busy=0; lasts exactly one cycle.
  - If start=1: same capture as in IDLE, next state RUN (back-to-back requests).
  - Otherwise next state IDLE.
- start is ignored in RUN: it is not queued and causes no error.
- a, b and mode are don't-care outside the capture edge. Changing them during RUN has no effect.
- Arithmetic:
  - acc and count are CW bits wide; the maximum value WIDTH always fits, so overflow is impossible.
  - The chunk popcount is zero-extended to CW before the add.
- count changes only at the edge entering DONE, or on reset.
- Reset, in any state including mid-RUN:
  - next cycle: state IDLE, busy=0, done=0, count=0, acc=0, idx=0;
  - an in-flight request is dropped with no done pulse;
  - reset has priority over start in the same cycle.
- CHUNK=WIDTH (N=1) is legal: one RUN cycle.

## Timing
- start=1 in cycle 0 (state IDLE or DONE).
- busy=1 in cycles 1..N.
- done=1 and count valid in cycle N+1.
- Latency from start to done is N+1 cycles.
- Maximum throughput is one result per N+1 cycles, reached by asserting start in each DONE cycle.
- With WIDTH=16, CHUNK=4: busy in cycles 1–4, done in cycle 5; the next back-to-back done is in cycle 10.
- All outputs are registered or decoded directly from state, with no combinational path from inputs to outputs.
- Reset values: busy=0, done=0, count=0.

## Structure
- Package hamming_pkg:
  - `state_t` enum {IDLE, RUN, DONE};
  - a `popcount_width(w)` helper that returns `$clog2(w+1)`.
- Sub-module chunk_popcount #(CHUNK):
  - combinational CHUNK-bit ones counter;
  - output width `popcount_width(CHUNK)`;
  - one instance in hamming_seq.
- The top level holds the FSM, sr, acc, idx and the count register.

## Test plan
- **Weight, all ones.** WIDTH=16, CHUNK=4, mode=0, a=16'hFFFF, start in cycle 0 → busy in cycles 1–4, done in cycle 5 only, count=16.
- **Distance.** mode=1, a=16'hA5A5, b=16'h0F0F (a^b=16'hAAAA) → done in cycle 5, count=8. Changing a and b during RUN leaves the result unchanged.
- **start while busy.** a=16'h0001 with start in cycle 0, then a=16'hFFFF with start in cycle 2 → exactly one done (cycle 5), count=1, no further busy.
- **Back-to-back with reset.**
  - First result count=16; start in DONE (cycle 5) with a=16'h00FF, mode=0.
  - Required: busy in cycles 6–9, done in cycle 10 with count=8; count holds 16 during cycles 6–9.
  - Then start a=16'hFFFF and assert reset in cycle 2 of RUN → next cycle busy=0, done=0, count=0, no done pulse.
- **Exhaustive.**
  - Configurations: WIDTH=16/CHUNK=4; WIDTH=16/CHUNK=16 (N=1, done in cycle 2); WIDTH=8/CHUNK=2.
  - Cover all a values with mode=0, and random a/b pairs with mode=1.
  - count must equal a sequential loop-sum reference; any mismatch triggers `$fatal` with the operands and both counts printed.
